// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM state type, address width and R/W encoding,
// plus the address-compare helper used by the target.
package i2c_pkg;

   localparam int   I2C_ADDR_W  = 7;
   localparam logic I2C_RW_READ = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_WR_DATA,
      S_WR_ACK,
      S_RD_DATA,
      S_RD_ACK,
      S_WAIT_STOP
   } i2c_slv_state_t;

   // General call (address 0) is never answered, whatever the own address is.
   function automatic logic i2c_addr_match(input logic [I2C_ADDR_W-1:0] bus_addr,
                                           input logic [I2C_ADDR_W-1:0] own_addr);
      return (bus_addr == own_addr) && (bus_addr != '0);
   endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA input conditioning: SYNC_STAGES-deep synchronizers (minimum 2), one
// edge-detect register per line, and SCL edge / START / STOP event decode.
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_rise,
   output logic scl_fall,
   output logic sda_s,
   output logic start_det,
   output logic stop_det
);

   // Line index 1 is SCL, index 0 is SDA.
   logic [1:0] line_in;
   logic [1:0] line_s;
   logic [1:0] line_prev;

   assign line_in = {scl_in, sda_in};

   for (genvar gi = 0; gi < 2; gi++) begin : g_line
      logic [SYNC_STAGES-1:0] sync_q;
      logic [SYNC_STAGES-1:0] sync_d;
      logic                   prev_q;
      logic                   prev_d;

      // Shift the raw pin into the synchronizer; remember the last synced value.
      always_comb begin
         sync_d = {sync_q[SYNC_STAGES-2:0], line_in[gi]};
         prev_d = sync_q[SYNC_STAGES-1];
      end

      // Lines reset to the idle-bus level (released, pulled high).
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
         end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
         end
      end

      assign line_s[gi]    = sync_q[SYNC_STAGES-1];
      assign line_prev[gi] = prev_q;
   end

   logic scl_s;
   logic scl_p;
   logic sda_p;

   assign scl_s = line_s[1];
   assign scl_p = line_prev[1];
   assign sda_s = line_s[0];
   assign sda_p = line_prev[0];

   // SCL must be high in both samples so an SDA change coinciding with an SCL
   // edge is never taken for a bus condition.
   assign scl_rise  =  scl_s & ~scl_p;
   assign scl_fall  = ~scl_s &  scl_p;
   assign start_det =  scl_s &  scl_p & ~sda_s &  sda_p;
   assign stop_det  =  scl_s &  scl_p &  sda_s & ~sda_p;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: address match + ACK, byte receive into rx_data, byte transmit
// from tx_data, open-drain SDA driver. SDA changes one clk after the synced
// SCL fall, giving an SCL-edge to SDA latency of SYNC_STAGES+2 clk.
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h42,
   parameter int                    SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i2c_scl,
   inout  wire        i2c_sda,
   input  logic [7:0] tx_data,
   input  logic       rx_full,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       tx_req,
   output logic       busy
);

   logic scl_rise;
   logic scl_fall;
   logic sda_s;
   logic start_det;
   logic stop_det;

   i2c_bus_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .reset    (reset),
      .scl_in   (i2c_scl),
      .sda_in   (i2c_sda),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .sda_s    (sda_s),
      .start_det(start_det),
      .stop_det (stop_det)
   );

   i2c_slv_state_t state_q,    state_d;
   logic [2:0]     bit_cnt_q,  bit_cnt_d;
   logic [7:0]     shift_q,    shift_d;
   logic           rw_q,       rw_d;
   logic           ack_clk_q,  ack_clk_d;   // ACK clock pulse already seen in this ACK slot
   logic           ack_low_q,  ack_low_d;   // write byte will be ACKed
   logic           busy_q,     busy_d;
   logic [7:0]     rx_data_q,  rx_data_d;
   logic           rx_valid_q, rx_valid_d;
   logic           tx_req_q,   tx_req_d;
   logic           drv_pend_q, drv_pend_d;  // an SDA update is due next clk
   logic           drv_low_q,  drv_low_d;   // value of that update (1 = pull low)
   logic           sda_low_q,  sda_low_d;

   // State register and datapath flops; reset releases SDA immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= 3'd7;
         shift_q    <= 8'h00;
         rw_q       <= 1'b0;
         ack_clk_q  <= 1'b0;
         ack_low_q  <= 1'b0;
         busy_q     <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         tx_req_q   <= 1'b0;
         drv_pend_q <= 1'b0;
         drv_low_q  <= 1'b0;
         sda_low_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         rw_q       <= rw_d;
         ack_clk_q  <= ack_clk_d;
         ack_low_q  <= ack_low_d;
         busy_q     <= busy_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_req_q   <= tx_req_d;
         drv_pend_q <= drv_pend_d;
         drv_low_q  <= drv_low_d;
         sda_low_q  <= sda_low_d;
      end
   end

   // Next-state logic: bus conditions first, then per-state bit handling.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      rw_d       = rw_q;
      ack_clk_d  = ack_clk_q;
      ack_low_d  = ack_low_q;
      busy_d     = busy_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      tx_req_d   = 1'b0;
      drv_pend_d = 1'b0;
      drv_low_d  = drv_low_q;
      sda_low_d  = sda_low_q;

      // Apply the SDA value decided at the previous clk's SCL fall.
      if (drv_pend_q) begin
         sda_low_d = drv_low_q;
      end

      // tx_data is captured in the cycle tx_req is high.
      if (tx_req_q) begin
         shift_d = tx_data;
      end

      if (stop_det) begin
         state_d   = S_IDLE;
         sda_low_d = 1'b0;
         busy_d    = 1'b0;
         ack_clk_d = 1'b0;
         bit_cnt_d = 3'd7;
      end else if (start_det) begin
         state_d   = S_ADDR;
         sda_low_d = 1'b0;
         busy_d    = 1'b0;
         ack_clk_d = 1'b0;
         bit_cnt_d = 3'd7;
      end else begin
         case (state_q)
            S_ADDR: begin
               if (scl_rise) begin
                  shift_d = {shift_q[6:0], sda_s};
                  if (bit_cnt_q == 3'd0) begin
                     // shift_q[6:0] holds the address, sda_s is the R/W bit.
                     if (i2c_addr_match(shift_q[6:0], SLAVE_ADDR)) begin
                        state_d   = S_ADDR_ACK;
                        busy_d    = 1'b1;
                        rw_d      = sda_s;
                        ack_clk_d = 1'b0;
                        tx_req_d  = (sda_s == I2C_RW_READ);
                     end else begin
                        state_d = S_WAIT_STOP;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q - 3'd1;
                  end
               end
            end

            S_ADDR_ACK: begin
               if (scl_rise) begin
                  ack_clk_d = 1'b1;
               end
               if (scl_fall) begin
                  drv_pend_d = 1'b1;
                  if (!ack_clk_q) begin
                     drv_low_d = 1'b1;
                  end else begin
                     ack_clk_d = 1'b0;
                     bit_cnt_d = 3'd7;
                     if (rw_q == I2C_RW_READ) begin
                        state_d   = S_RD_DATA;
                        drv_low_d = ~shift_q[7];
                     end else begin
                        state_d   = S_WR_DATA;
                        drv_low_d = 1'b0;
                     end
                  end
               end
            end

            S_WR_DATA: begin
               if (scl_rise) begin
                  shift_d = {shift_q[6:0], sda_s};
                  if (bit_cnt_q == 3'd0) begin
                     state_d   = S_WR_ACK;
                     ack_clk_d = 1'b0;
                     ack_low_d = ~rx_full;
                     if (!rx_full) begin
                        rx_data_d  = {shift_q[6:0], sda_s};
                        rx_valid_d = 1'b1;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q - 3'd1;
                  end
               end
            end

            S_WR_ACK: begin
               if (scl_rise) begin
                  ack_clk_d = 1'b1;
               end
               if (scl_fall) begin
                  drv_pend_d = 1'b1;
                  if (!ack_clk_q) begin
                     drv_low_d = ack_low_q;
                  end else begin
                     drv_low_d = 1'b0;
                     state_d   = S_WR_DATA;
                     bit_cnt_d = 3'd7;
                     ack_clk_d = 1'b0;
                  end
               end
            end

            S_RD_DATA: begin
               // The bit on the bus is always shift_q[7]; each fall moves to the next.
               if (scl_fall) begin
                  drv_pend_d = 1'b1;
                  if (bit_cnt_q == 3'd0) begin
                     drv_low_d = 1'b0;
                     state_d   = S_RD_ACK;
                     ack_clk_d = 1'b0;
                  end else begin
                     drv_low_d = ~shift_q[6];
                     shift_d   = {shift_q[6:0], 1'b0};
                     bit_cnt_d = bit_cnt_q - 3'd1;
                  end
               end
            end

            S_RD_ACK: begin
               if (scl_rise) begin
                  if (!sda_s) begin
                     ack_clk_d = 1'b1;
                     tx_req_d  = 1'b1;
                  end else begin
                     state_d = S_WAIT_STOP;
                     busy_d  = 1'b0;
                  end
               end
               if (scl_fall && ack_clk_q) begin
                  drv_pend_d = 1'b1;
                  drv_low_d  = ~shift_q[7];
                  state_d    = S_RD_DATA;
                  bit_cnt_d  = 3'd7;
                  ack_clk_d  = 1'b0;
               end
            end

            default: begin
               // S_IDLE and S_WAIT_STOP: only START/STOP act.
            end
         endcase
      end
   end

   assign i2c_sda  = sda_low_q ? 1'b0 : 1'bz;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign tx_req   = tx_req_q;
   assign busy     = busy_q;

endmodule
